// File: rtl/ex_div_ctrl.sv
// EX-stage divide controller: 32-cycle restoring divider with sign fix-up,
// divide-by-zero shortcut, annul and a valid/hold handshake toward EX.
module ex_div_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                stallreq_o
);

  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BYZERO,
    S_ON,
    S_END
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [CW-1:0]       cnt_q;
  logic [2*DATA_W:0]   work_q;
  logic [2*DATA_W:0]   work_step;
  logic [DATA_W-1:0]   dvs_q;
  logic                neg_quo_q;
  logic                neg_rem_q;

  logic                accept;
  logic                last_step;
  logic                op1_neg;
  logic                op2_neg;
  logic [DATA_W-1:0]   op1_abs;
  logic [DATA_W-1:0]   op2_abs;
  logic [DATA_W+1:0]   trial;
  logic                ge;
  logic [DATA_W:0]     sub;
  logic [DATA_W-1:0]   quo;
  logic [DATA_W-1:0]   rem;
  logic [DATA_W-1:0]   quo_fix;
  logic [DATA_W-1:0]   rem_fix;

  logic                ready_d;
  logic [2*DATA_W-1:0] result_d;

  assign accept    = (state_q == S_IDLE) && start_i && !annul_i;
  assign last_step = (cnt_q == CNT_LAST);

  assign op1_neg = signed_div_i & opdata1_i[DATA_W-1];
  assign op2_neg = signed_div_i & opdata2_i[DATA_W-1];
  assign op1_abs = op1_neg ? -opdata1_i : opdata1_i;
  assign op2_abs = op2_neg ? -opdata2_i : opdata2_i;

  // work = {partial remainder, dividend bits being shifted out / quotient in}
  assign trial = {work_q[2*DATA_W:DATA_W], work_q[DATA_W-1]};
  assign ge    = trial >= {2'b00, dvs_q};
  assign sub   = trial[DATA_W:0] - {1'b0, dvs_q};

  assign work_step = ge ?
    {sub, work_q[DATA_W-2:0], 1'b1} :
    {trial[DATA_W:0], work_q[DATA_W-2:0], 1'b0};

  assign quo     = work_step[DATA_W-1:0];
  assign rem     = work_step[2*DATA_W-1:DATA_W];
  assign quo_fix = neg_quo_q ? -quo : quo;
  assign rem_fix = neg_rem_q ? -rem : rem;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = (opdata2_i == '0) ? S_BYZERO : S_ON;
        end
      end
      S_BYZERO: state_d = annul_i ? S_IDLE : S_END;
      S_ON: begin
        if (annul_i) begin
          state_d = S_IDLE;
        end else if (last_step) begin
          state_d = S_END;
        end
      end
      S_END: begin
        if (!start_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready_d    = 1'b0;
    result_d   = result_o;
    stallreq_o = start_i & ~ready_o & ~annul_i;
    unique case (state_q)
      S_IDLE:   result_d = '0;
      S_BYZERO: result_d = '0;
      S_ON: begin
        if (annul_i) begin
          result_d = '0;
        end else if (last_step) begin
          result_d = {rem_fix, quo_fix};
        end
      end
      S_END: begin
        ready_d  = start_i;
        result_d = start_i ? result_o : '0;
      end
      default: result_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q     <= '0;
      work_q    <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_o  <= '0;
      ready_o   <= 1'b0;
    end else begin
      result_o <= result_d;
      ready_o  <= ready_d;
      if (accept) begin
        cnt_q     <= '0;
        work_q    <= {{(DATA_W+1){1'b0}}, op1_abs};
        dvs_q     <= op2_abs;
        neg_quo_q <= op1_neg ^ op2_neg;
        neg_rem_q <= op1_neg;
      end else if (state_q == S_ON && !annul_i) begin
        work_q <= work_step;
        cnt_q  <= cnt_q + 1'b1;
      end
    end
  end

endmodule
